// File: rtl/mips_defs.sv
// Shared definitions for the boot-time instruction-memory loader:
// loader state encodings, header length width and a byte-packing helper.
package mips_defs;

    localparam int LEN_WIDTH  = 16;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_e;

    // Big-endian packing: earlier bytes migrate toward [31:24].
    function automatic logic [WORD_WIDTH-1:0] shift_in_byte(
        input logic [WORD_WIDTH-1:0] word,
        input logic [7:0]            new_byte
    );
        return {word[WORD_WIDTH-9:0], new_byte};
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects four stream bytes, MSB first, into one 32-bit instruction word.
module byte_assembler
    import mips_defs::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic                  clear,
    input  logic [7:0]            byte_in,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  last_byte
);

    logic [WORD_WIDTH-1:0] word_r;
    logic [1:0]            idx_r;

    // Shift register and byte index; clear wins so a stale partial word never leaks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_r <= {WORD_WIDTH{1'b0}};
            idx_r  <= 2'd0;
        end else if (clear) begin
            word_r <= {WORD_WIDTH{1'b0}};
            idx_r  <= 2'd0;
        end else if (shift_en) begin
            word_r <= shift_in_byte(word_r, byte_in);
            idx_r  <= idx_r + 2'd1;
        end else begin
            word_r <= word_r;
            idx_r  <= idx_r;
        end
    end

    assign word_out  = word_r;
    assign last_byte = (idx_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes big-endian words to
// instruction memory from address 0 and holds the core in reset until done.
module imem_loader
    import mips_defs::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_err
);

    // One extra bit lets a MAX_WORDS-long program finish without wrapping.
    localparam int          IDX_WIDTH   = ADDR_WIDTH + 1;
    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

    loader_state_e          state_r;
    loader_state_e          state_next_s;
    logic [LEN_WIDTH-1:0]   count_r;
    logic [LEN_WIDTH-1:0]   len_full_s;
    logic [IDX_WIDTH-1:0]   word_idx_r;
    logic [IDX_WIDTH-1:0]   idx_inc_s;
    logic                   accept_s;
    logic                   shift_en_s;
    logic                   clear_s;
    logic                   last_byte_s;
    logic [WORD_WIDTH-1:0]  word_s;

    assign in_ready   = (state_r == ST_LEN_HI) || (state_r == ST_LEN_LO) || (state_r == ST_DATA);
    assign accept_s   = in_ready && in_valid;
    assign len_full_s = {count_r[LEN_WIDTH-1:8], in_byte};
    assign idx_inc_s  = word_idx_r + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
    assign shift_en_s = (state_r == ST_DATA) && accept_s;

    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en_s),
        .clear     (clear_s),
        .byte_in   (in_byte),
        .word_out  (word_s),
        .last_byte (last_byte_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and assembler clear strobe.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next_s = ST_LEN_HI;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    state_next_s = ST_LEN_LO;
                end else begin
                    state_next_s = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (!accept_s) begin
                    state_next_s = ST_LEN_LO;
                end else if (len_full_s == {LEN_WIDTH{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else if ({16'd0, len_full_s} > MAX_WORDS_U) begin
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_DATA;
                    clear_s      = 1'b1;
                end
            end
            ST_DATA: begin
                if (accept_s && last_byte_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (LEN_WIDTH'(idx_inc_s) == count_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Header length capture and word index, advanced once per written word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r    <= {LEN_WIDTH{1'b0}};
            word_idx_r <= {IDX_WIDTH{1'b0}};
        end else begin
            if (state_r == ST_LEN_HI && accept_s) begin
                count_r <= {in_byte, count_r[7:0]};
            end else if (state_r == ST_LEN_LO && accept_s) begin
                count_r <= len_full_s;
            end else begin
                count_r <= count_r;
            end
            if (clear_s) begin
                word_idx_r <= {IDX_WIDTH{1'b0}};
            end else if (state_r == ST_WRITE) begin
                word_idx_r <= idx_inc_s;
            end else begin
                word_idx_r <= word_idx_r;
            end
        end
    end

    assign imem_we    = (state_r == ST_WRITE);
    assign imem_addr  = word_idx_r[ADDR_WIDTH-1:0];
    assign imem_wdata = word_s;
    assign core_reset = (state_r != ST_DONE);
    assign load_done  = (state_r == ST_DONE);
    assign load_err   = (state_r == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a
// negedge monitor pops and compares each imem_we pulse.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_err;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    int         n_checks = 0;
    int         n_fails = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         done_cyc = 0;
    int         writes_seen = 0;
    int         wr_before;
    logic       prev_we = 1'b0;
    logic       prev_done = 1'b0;

    imem_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (reset === 1'b1) begin
            if (imem_we === 1'b1) begin
                writes_seen++;
                check("we_single_cycle", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {31'd0, imem_we}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {24'd0, imem_addr}, {24'd0, e.addr});
                    check("wr_data", imem_wdata, e.data);
                end
            end
            if (load_done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
        end
        prev_we   = imem_we;
        prev_done = load_done;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_stream(input int gap);
        bit got;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (gap > 0 && i > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_byte  = stim_q[i];
            got      = 1'b0;
            for (int t = 0; t < 60; t++) begin
                @(negedge clk);
                if (in_ready === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            check("handshake_timeout", {31'd0, got}, 32'd1);
            if (i == 0) t0 = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (load_done === 1'b1) break;
        end
        check("done_timeout", {31'd0, load_done}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic two_word_stream();
        stim_q = '{8'h00, 8'h02, 8'h00, 8'h64, 8'h10, 8'h20, 8'h00, 8'h65, 8'h18, 8'h22};
        exp_q.push_back('{addr: 8'h00, data: 32'h00641020});
        exp_q.push_back('{addr: 8'h01, data: 32'h00651822});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a byte already on offer
        reset = 1'b0; start = 1'b0; in_valid = 1'b1; in_byte = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   {31'd0, in_ready},   32'd0);
        check("rst_imem_we",    {31'd0, imem_we},    32'd0);
        check("rst_imem_addr",  {24'd0, imem_addr},  32'd0);
        check("rst_imem_wdata", imem_wdata,          32'd0);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_load_done",  {31'd0, load_done},  32'd0);
        check("rst_load_err",   {31'd0, load_err},   32'd0);
        @(posedge clk); #1 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        // Two-word load, no gaps: DONE 12 cycles after first header byte
        two_word_stream();
        pulse_start();
        check("load_core_reset", {31'd0, core_reset}, 32'd1);
        send_stream(0);
        wait_done();
        check("two_word_done_cycle", done_cyc - t0, 32'd12);
        check("two_word_core_reset", {31'd0, core_reset}, 32'd0);
        check("two_word_err", {31'd0, load_err}, 32'd0);
        check("two_word_sb_empty", exp_q.size(), 32'd0);

        // Backpressure: three idle cycles between every byte
        two_word_stream();
        pulse_start();
        check("restart_core_reset", {31'd0, core_reset}, 32'd1);
        check("restart_done_clear", {31'd0, load_done}, 32'd0);
        send_stream(3);
        wait_done();
        check("bp_sb_empty", exp_q.size(), 32'd0);

        // Zero length
        wr_before = writes_seen;
        stim_q = '{8'h00, 8'h00};
        pulse_start();
        send_stream(0);
        wait_done();
        check("zero_done_cycle", done_cyc - t0, 32'd2);
        check("zero_core_reset", {31'd0, core_reset}, 32'd0);
        check("zero_no_write", writes_seen - wr_before, 32'd0);

        // Overflow: 257 words against MAX_WORDS=256
        wr_before = writes_seen;
        stim_q = '{8'h01, 8'h01};
        pulse_start();
        send_stream(0);
        @(negedge clk);
        check("ovf_load_err",   {31'd0, load_err},   32'd1);
        check("ovf_in_ready",   {31'd0, in_ready},   32'd0);
        check("ovf_core_reset", {31'd0, core_reset}, 32'd1);
        check("ovf_load_done",  {31'd0, load_done},  32'd0);
        in_valid = 1'b1; in_byte = 8'h55;
        repeat (5) @(negedge clk);
        check("ovf_hold_ready", {31'd0, in_ready}, 32'd0);
        check("ovf_no_write", writes_seen - wr_before, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        stim_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back('{addr: 8'h00, data: 32'h00000000});
        pulse_start();
        send_stream(0);
        wait_done();
        check("recover_load_err", {31'd0, load_err}, 32'd0);
        check("recover_sb_empty", exp_q.size(), 32'd0);

        // Reset after two data bytes of word 0
        wr_before = writes_seen;
        stim_q = '{8'h00, 8'h02, 8'h00, 8'h64};
        pulse_start();
        send_stream(0);
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready",   {31'd0, in_ready},   32'd0);
        check("midrst_core_reset", {31'd0, core_reset}, 32'd1);
        check("midrst_load_done",  {31'd0, load_done},  32'd0);
        check("midrst_wdata",      imem_wdata,          32'd0);
        repeat (4) @(negedge clk);
        check("midrst_no_write", writes_seen - wr_before, 32'd0);
        check("midrst_idle_ready", {31'd0, in_ready}, 32'd0);
        two_word_stream();
        pulse_start();
        send_stream(0);
        wait_done();
        check("reload_done_cycle", done_cyc - t0, 32'd12);
        check("reload_sb_empty", exp_q.size(), 32'd0);
        check("total_writes", writes_seen, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
